// File: rtl/led_blink_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_blink_array : multi-channel LED driver with shared timebase prescaler
// Rev 1.0
// ----------------------------------------------------------------------------
module led_blink_array #(
  parameter int                  NUM_LEDS       = 4,
  parameter int                  PRESCALE       = 100000,
  parameter int                  HP_WIDTH       = 16,
  parameter int                  BURST_WIDTH    = 8,
  parameter int                  DEFAULT_HP     = 500,
  parameter logic [NUM_LEDS-1:0] RST_BLINK_MASK = '1,
  parameter int                  ADDR_W         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [ADDR_W-1:0]      cfg_addr,
  input  logic [1:0]             cfg_mode,
  input  logic [HP_WIDTH-1:0]    cfg_half_period,
  input  logic [BURST_WIDTH-1:0] cfg_burst,
  output logic [NUM_LEDS-1:0]    led,
  output logic [NUM_LEDS-1:0]    busy,
  output logic [NUM_LEDS-1:0]    burst_done,
  output logic                   tick
);

  localparam int                  c_cnt_w  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_max = c_cnt_w'(PRESCALE - 1);
  localparam logic [HP_WIDTH-1:0] c_rst_hp  = (DEFAULT_HP == 0) ? HP_WIDTH'(1) : HP_WIDTH'(DEFAULT_HP);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               w_wrap;

  // Channels act on the same edge that raises tick, so LED edges line up with tick=1.
  always_comb begin
    w_wrap = (cnt_q == c_cnt_max);
    cnt_d  = w_wrap ? '0 : cnt_q + c_cnt_w'(1);
    tick_d = w_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    mode_e                  mode_q, mode_d;
    logic                   led_q, led_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [HP_WIDTH-1:0]    phase_q, phase_d;
    logic [HP_WIDTH-1:0]    hp_q, hp_d;
    logic [BURST_WIDTH-1:0] rem_q, rem_d;
    logic                   w_sel;
    logic                   w_last;

    always_comb begin
      mode_d  = mode_q;
      led_d   = led_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      phase_d = phase_q;
      hp_d    = hp_q;
      rem_d   = rem_q;
      w_sel   = cfg_we && (cfg_addr == ADDR_W'(i));
      w_last  = (phase_q == hp_q - HP_WIDTH'(1));

      if (w_sel) begin
        // A write always wins over a coincident tick and aborts any burst silently.
        phase_d = '0;
        hp_d    = (cfg_half_period == '0) ? HP_WIDTH'(1) : cfg_half_period;
        rem_d   = '0;
        busy_d  = 1'b0;
        case (cfg_mode)
          2'd0: begin mode_d = MODE_OFF;   led_d = 1'b0; end
          2'd1: begin mode_d = MODE_ON;    led_d = 1'b1; end
          2'd2: begin mode_d = MODE_BLINK; led_d = 1'b1; end
          default: begin
            if (cfg_burst != '0) begin
              mode_d = MODE_BURST;
              led_d  = 1'b1;
              rem_d  = cfg_burst;
              busy_d = 1'b1;
            end else begin
              mode_d = MODE_OFF;
              led_d  = 1'b0;
            end
          end
        endcase
      end else if (w_wrap && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
        if (w_last) begin
          phase_d = '0;
          led_d   = ~led_q;
          if (mode_q == MODE_BURST && led_q) begin
            if (rem_q == BURST_WIDTH'(1)) begin
              mode_d = MODE_OFF;
              led_d  = 1'b0;
              busy_d = 1'b0;
              done_d = 1'b1;
              rem_d  = '0;
            end else begin
              rem_d = rem_q - BURST_WIDTH'(1);
            end
          end
        end else begin
          phase_d = phase_q + HP_WIDTH'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mode_q  <= RST_BLINK_MASK[i] ? MODE_BLINK : MODE_OFF;
        led_q   <= RST_BLINK_MASK[i];
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        phase_q <= '0;
        hp_q    <= c_rst_hp;
        rem_q   <= '0;
      end else begin
        mode_q  <= mode_d;
        led_q   <= led_d;
        busy_q  <= busy_d;
        done_q  <= done_d;
        phase_q <= phase_d;
        hp_q    <= hp_d;
        rem_q   <= rem_d;
      end
    end

    assign led[i]        = led_q;
    assign busy[i]       = busy_q;
    assign burst_done[i] = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_led_blink_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_led_blink_array : directed self-checking bench for led_blink_array
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_led_blink_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_half_period = '0;
  logic [7:0] cfg_burst = '0;
  logic [3:0] led, busy, burst_done;
  logic       tick;
  logic [2:0] led2, busy2, done2;
  logic       tick2;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] done_acc = '0;
  int         done_cnt = 0;

  always #5 clk = ~clk;

  led_blink_array #(
    .NUM_LEDS(4), .PRESCALE(4), .HP_WIDTH(8), .BURST_WIDTH(8),
    .DEFAULT_HP(2), .RST_BLINK_MASK(4'b0001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period), .cfg_burst(cfg_burst),
    .led(led), .busy(busy), .burst_done(burst_done), .tick(tick)
  );

  led_blink_array #(
    .NUM_LEDS(3), .PRESCALE(4), .HP_WIDTH(8), .BURST_WIDTH(8),
    .DEFAULT_HP(2), .RST_BLINK_MASK(3'b001)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period), .cfg_burst(cfg_burst),
    .led(led2), .busy(busy2), .burst_done(done2), .tick(tick2)
  );

  // Advance n rising edges and settle 1 ns past the last one; record done pulses.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      done_acc = done_acc | burst_done;
      if (burst_done[1]) done_cnt++;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [1:0] m,
                           input logic [7:0] hp, input logic [7:0] b);
    cfg_addr = a; cfg_mode = m; cfg_half_period = hp; cfg_burst = b;
    cfg_we = 1'b1;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(3);
    n_cmp++; if (led !== 4'b0001) begin n_bad++; $display("FAIL rst_led got=%b exp=%b", led, 4'b0001); end
    n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL rst_busy got=%b exp=%b", busy, 4'b0000); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick got=%b exp=%b", tick, 1'b0); end
    n_cmp++; if (burst_done !== 4'b0000) begin n_bad++; $display("FAIL rst_done got=%b exp=%b", burst_done, 4'b0000); end
    rst_n = 1'b1;
    step(3);   // E3
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL tick_e3 got=%b exp=%b", tick, 1'b0); end
    step(1);   // E4: first tick
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL tick_e4 got=%b exp=%b", tick, 1'b1); end
    n_cmp++; if (led !== 4'b0001) begin n_bad++; $display("FAIL led_e4 got=%b exp=%b", led, 4'b0001); end
    step(1);   // E5
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL tick_e5 got=%b exp=%b", tick, 1'b0); end
    step(3);   // E8: second tick, led0 falls
    n_cmp++; if (led !== 4'b0000) begin n_bad++; $display("FAIL led_e8 got=%b exp=%b", led, 4'b0000); end
    step(7);   // E15
    n_cmp++; if (led !== 4'b0000) begin n_bad++; $display("FAIL led_e15 got=%b exp=%b", led, 4'b0000); end
    step(1);   // E16
    n_cmp++; if (led !== 4'b0001) begin n_bad++; $display("FAIL led_e16 got=%b exp=%b", led, 4'b0001); end
  endtask

  task automatic test_blink;
    cfg_write(2'd2, 2'd2, 8'd3, 8'd0);   // E17
    n_cmp++; if (led !== 4'b0101) begin n_bad++; $display("FAIL blink_e17 got=%b exp=%b", led, 4'b0101); end
    step(10);  // E27
    n_cmp++; if (led !== 4'b0100) begin n_bad++; $display("FAIL blink_e27 got=%b exp=%b", led, 4'b0100); end
    step(1);   // E28: ch2 falls after 3 ticks
    n_cmp++; if (led !== 4'b0000) begin n_bad++; $display("FAIL blink_e28 got=%b exp=%b", led, 4'b0000); end
    step(11);  // E39
    n_cmp++; if (led !== 4'b0001) begin n_bad++; $display("FAIL blink_e39 got=%b exp=%b", led, 4'b0001); end
    step(1);   // E40: ch2 rises, ch0 falls
    n_cmp++; if (led !== 4'b0100) begin n_bad++; $display("FAIL blink_e40 got=%b exp=%b", led, 4'b0100); end
  endtask

  task automatic test_burst;
    done_acc = '0; done_cnt = 0;
    cfg_write(2'd1, 2'd3, 8'd1, 8'd2);   // E41
    n_cmp++; if (led !== 4'b0110) begin n_bad++; $display("FAIL burst_led_e41 got=%b exp=%b", led, 4'b0110); end
    n_cmp++; if (busy !== 4'b0010) begin n_bad++; $display("FAIL burst_busy_e41 got=%b exp=%b", busy, 4'b0010); end
    step(3);   // E44: first fall
    n_cmp++; if (led !== 4'b0100) begin n_bad++; $display("FAIL burst_led_e44 got=%b exp=%b", led, 4'b0100); end
    n_cmp++; if (busy !== 4'b0010) begin n_bad++; $display("FAIL burst_busy_e44 got=%b exp=%b", busy, 4'b0010); end
    step(4);   // E48: rise
    n_cmp++; if (led !== 4'b0111) begin n_bad++; $display("FAIL burst_led_e48 got=%b exp=%b", led, 4'b0111); end
    step(3);   // E51
    n_cmp++; if (done_acc !== 4'b0000) begin n_bad++; $display("FAIL burst_early_done got=%b exp=%b", done_acc, 4'b0000); end
    step(1);   // E52: final fall with done
    n_cmp++; if (led !== 4'b0001) begin n_bad++; $display("FAIL burst_led_e52 got=%b exp=%b", led, 4'b0001); end
    n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL burst_busy_e52 got=%b exp=%b", busy, 4'b0000); end
    n_cmp++; if (burst_done !== 4'b0010) begin n_bad++; $display("FAIL burst_done_e52 got=%b exp=%b", burst_done, 4'b0010); end
    step(1);   // E53
    n_cmp++; if (burst_done !== 4'b0000) begin n_bad++; $display("FAIL burst_done_e53 got=%b exp=%b", burst_done, 4'b0000); end
  endtask

  task automatic test_collision;
    step(6);   // E59
    cfg_write(2'd0, 2'd2, 8'd2, 8'd0);   // E60 is a tick edge
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL coll_tick got=%b exp=%b", tick, 1'b1); end
    n_cmp++; if (led !== 4'b0001) begin n_bad++; $display("FAIL coll_led_e60 got=%b exp=%b", led, 4'b0001); end
    step(4);   // E64: ch0 holds, ch2 rises (it counted the E60 tick)
    n_cmp++; if (led !== 4'b0101) begin n_bad++; $display("FAIL coll_led_e64 got=%b exp=%b", led, 4'b0101); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL burst_done_count got=%0d exp=%0d", done_cnt, 1); end
    step(3);   // E67
    n_cmp++; if (led !== 4'b0101) begin n_bad++; $display("FAIL coll_led_e67 got=%b exp=%b", led, 4'b0101); end
    step(1);   // E68: ch0 falls two full ticks after the write
    n_cmp++; if (led !== 4'b0100) begin n_bad++; $display("FAIL coll_led_e68 got=%b exp=%b", led, 4'b0100); end
  endtask

  task automatic test_abort;
    done_acc = '0;
    cfg_write(2'd1, 2'd3, 8'd1, 8'd3);   // E69
    n_cmp++; if ({led[1], busy[1]} !== 2'b11) begin n_bad++; $display("FAIL abort_start got=%b exp=%b", {led[1], busy[1]}, 2'b11); end
    step(7);   // E76
    n_cmp++; if ({led[1], busy[1]} !== 2'b11) begin n_bad++; $display("FAIL abort_mid got=%b exp=%b", {led[1], busy[1]}, 2'b11); end
    cfg_write(2'd1, 2'd1, 8'd1, 8'd0);   // E77: ON aborts burst
    n_cmp++; if (led[1] !== 1'b1) begin n_bad++; $display("FAIL abort_led got=%b exp=%b", led[1], 1'b1); end
    n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL abort_busy got=%b exp=%b", busy, 4'b0000); end
    step(12);  // E89
    n_cmp++; if (done_acc !== 4'b0000) begin n_bad++; $display("FAIL abort_done got=%b exp=%b", done_acc, 4'b0000); end
    n_cmp++; if (led[1] !== 1'b1) begin n_bad++; $display("FAIL abort_hold got=%b exp=%b", led[1], 1'b1); end
    cfg_write(2'd1, 2'd3, 8'd1, 8'd3);   // E90
    step(2);   // E92: first fall
    n_cmp++; if ({led[1], busy[1]} !== 2'b01) begin n_bad++; $display("FAIL rstab_mid got=%b exp=%b", {led[1], busy[1]}, 2'b01); end
    step(2);
    rst_n = 1'b0;
    step(1);
    n_cmp++; if (led !== 4'b0001) begin n_bad++; $display("FAIL rstab_led got=%b exp=%b", led, 4'b0001); end
    n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL rstab_busy got=%b exp=%b", busy, 4'b0000); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL rstab_tick got=%b exp=%b", tick, 1'b0); end
    step(1);
    rst_n = 1'b1;
    step(12);  // E12 after release
    n_cmp++; if (done_acc !== 4'b0000) begin n_bad++; $display("FAIL rstab_done got=%b exp=%b", done_acc, 4'b0000); end
    n_cmp++; if (led !== 4'b0000) begin n_bad++; $display("FAIL rstab_led_e12 got=%b exp=%b", led, 4'b0000); end
  endtask

  task automatic test_edges;
    cfg_write(2'd3, 2'd1, 8'd1, 8'd0);   // E13: addr 3 invalid on 3-channel instance
    n_cmp++; if (led !== 4'b1000) begin n_bad++; $display("FAIL edge_valid3 got=%b exp=%b", led, 4'b1000); end
    n_cmp++; if (led2 !== 3'b000) begin n_bad++; $display("FAIL edge_oob_led got=%b exp=%b", led2, 3'b000); end
    n_cmp++; if ({busy2, done2, tick2} !== 7'b0) begin n_bad++; $display("FAIL edge_oob_misc got=%b exp=%b", {busy2, done2, tick2}, 7'b0); end
    cfg_write(2'd2, 2'd2, 8'd0, 8'd0);   // E14: hp=0 acts as hp=1
    n_cmp++; if (led[2] !== 1'b1) begin n_bad++; $display("FAIL hp0_e14 got=%b exp=%b", led[2], 1'b1); end
    step(2);   // E16
    n_cmp++; if (led[2] !== 1'b0) begin n_bad++; $display("FAIL hp0_e16 got=%b exp=%b", led[2], 1'b0); end
    step(4);   // E20
    n_cmp++; if (led[2] !== 1'b1) begin n_bad++; $display("FAIL hp0_e20 got=%b exp=%b", led[2], 1'b1); end
    done_acc = '0;
    cfg_write(2'd1, 2'd1, 8'd1, 8'd0);   // E21
    n_cmp++; if (led[1] !== 1'b1) begin n_bad++; $display("FAIL b0_on got=%b exp=%b", led[1], 1'b1); end
    cfg_write(2'd1, 2'd3, 8'd1, 8'd0);   // E22: BURST with count 0 acts as OFF
    n_cmp++; if ({led[1], busy[1]} !== 2'b00) begin n_bad++; $display("FAIL b0_off got=%b exp=%b", {led[1], busy[1]}, 2'b00); end
    step(8);   // E30
    n_cmp++; if (done_acc !== 4'b0000) begin n_bad++; $display("FAIL b0_done got=%b exp=%b", done_acc, 4'b0000); end
    n_cmp++; if ({led[1], busy[1]} !== 2'b00) begin n_bad++; $display("FAIL b0_hold got=%b exp=%b", {led[1], busy[1]}, 2'b00); end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_collision();
    test_abort();
    test_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
